// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_unit_pkg;

    localparam int unsigned INST_W = 32;

    // Default first fetch address after reset (word aligned).
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef logic [INST_W-1:0] inst_t;

    // What happens to a memory response arriving in the current cycle.
    typedef enum logic [1:0] {
        RSP_NONE,     // no response this cycle
        RSP_DROP,     // stale response, consumed by the drop counter
        RSP_FILL,     // written into the oldest unfilled queue entry
        RSP_FLUSHED   // arrived during a redirect, folded into the new drop count
    } rsp_kind_e;

    // Canonical NOP (addi x0,x0,0) that decode substitutes on a flush.
    function automatic inst_t nop_inst();
        return 32'h0000_0013;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side handshakes: instruction memory request/response, redirect, decode output.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    inst_t           imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    inst_t           inst_out;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_pc_inc;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_out, inst_pc, inst_pc_inc,
        input  inst_ready
    );

    // Memory / decode / branch-unit side.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_out, inst_pc, inst_pc_inc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_unit_queue.sv
// In-order prefetch queue: entries are allocated at the tail when a request is
// accepted, filled in order as responses return, and popped from the head.
module fetch_unit_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc,
    input  logic [XLEN-1:0]            alloc_pc,
    input  logic                       fill,
    input  inst_t                      fill_data,
    input  logic                       pop,
    output logic                       head_ready,
    output logic [XLEN-1:0]            head_pc,
    output inst_t                      head_inst,
    output logic [$clog2(DEPTH+1)-1:0] alloc_cnt,
    output logic [$clog2(DEPTH+1)-1:0] unfilled_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fill_ptr;
    logic [XLEN-1:0]  pc_q [DEPTH];
    inst_t            inst_q [DEPTH];
    logic [DEPTH-1:0] filled;

    // Pointer and occupancy bookkeeping; a flush empties the queue outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= '0;
            tail         <= '0;
            fill_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            fill_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
        end else begin
            if (alloc) tail     <= tail + PTR_W'(1);
            if (fill)  fill_ptr <= fill_ptr + PTR_W'(1);
            if (pop)   head     <= head + PTR_W'(1);
            alloc_cnt    <= alloc_cnt + CNT_W'(alloc) - CNT_W'(pop);
            unfilled_cnt <= unfilled_cnt + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    // Entry storage. Alloc (at the free tail) and fill (at an already allocated
    // entry) never target the same slot in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            filled <= '0;
        end else if (flush) begin
            filled <= '0;
        end else begin
            if (alloc) begin
                pc_q[tail]   <= alloc_pc;
                filled[tail] <= 1'b0;
            end
            if (fill) begin
                inst_q[fill_ptr] <= fill_data;
                filled[fill_ptr] <= 1'b1;
            end
        end
    end

    // Head view: only registered state, so a same-cycle fill is never bypassed.
    always_comb begin
        head_ready = (alloc_cnt != '0) && filled[head];
        head_pc    = pc_q[head];
        head_inst  = inst_q[head];
    end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage: PC register, request issue gating,
// stale-response drop counter and redirect handling around the prefetch queue.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    localparam int unsigned     CNT_W   = $clog2(DEPTH+1);
    localparam logic [CNT_W:0]  DEPTH_W = (CNT_W+1)'(DEPTH);

    logic [XLEN-1:0]  fetch_pc;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] alloc_cnt;
    logic [CNT_W-1:0] unfilled_cnt;
    logic             req_fire;
    logic             pop;
    logic             fill;
    logic             head_ready;
    logic [XLEN-1:0]  head_pc;
    inst_t            head_inst;
    rsp_kind_e        rsp_kind;

    // Issue gating and decode-side outputs. Outstanding requests are the
    // allocated entries plus the stale ones still owed by memory.
    always_comb begin
        bus.imem_req_valid = rst && !bus.redirect_valid &&
                             (({1'b0, alloc_cnt} + {1'b0, drop}) < DEPTH_W);
        bus.imem_req_addr  = fetch_pc;
        bus.inst_valid     = rst && head_ready && !bus.redirect_valid;
        bus.inst_out       = head_inst;
        bus.inst_pc        = head_pc;
        bus.inst_pc_inc    = head_pc + XLEN'(4);
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;
        pop                = bus.inst_valid && bus.inst_ready;
    end

    // Classify the incoming response.
    always_comb begin
        rsp_kind = RSP_NONE;
        if (bus.imem_rsp_valid) begin
            if (bus.redirect_valid)
                rsp_kind = RSP_FLUSHED;
            else if (drop != '0)
                rsp_kind = RSP_DROP;
            else if (unfilled_cnt != '0)
                rsp_kind = RSP_FILL;
        end
        fill = (rsp_kind == RSP_FILL);
    end

    // Fetch PC: redirect target (word aligned) or advance on each accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fetch_pc <= RESET_PC;
        else if (bus.redirect_valid)
            fetch_pc <= bus.redirect_pc & ~XLEN'(3);
        else if (req_fire)
            fetch_pc <= fetch_pc + XLEN'(4);
    end

    // Drop counter: on redirect every unfilled entry becomes a stale response
    // still owed by memory, less one if it is arriving right now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop <= '0;
        else if (bus.redirect_valid)
            drop <= CNT_W'({1'b0, drop} + {1'b0, unfilled_cnt} -
                           (CNT_W+1)'(bus.imem_rsp_valid));
        else if (rsp_kind == RSP_DROP)
            drop <= drop - CNT_W'(1);
    end

    fetch_unit_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .flush        (bus.redirect_valid),
        .alloc        (req_fire),
        .alloc_pc     (fetch_pc),
        .fill         (fill),
        .fill_data    (bus.imem_rsp_data),
        .pop          (pop),
        .head_ready   (head_ready),
        .head_pc      (head_pc),
        .head_inst    (head_inst),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle tables, a mid-run reset sequence and a
// randomized run against a queue-based reference model with a latency memory.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic        rst_first;
        logic        rdy;
        logic        rsp_v;
        logic [31:0] rsp_pc;
        logic        ird;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ment_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                                input logic [31:0] rspc, input logic ird,
                                input logic redir, input logic [31:0] rpc,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic eiv, input logic [31:0] epc);
        vec_t v;
        v.rst_first = r;   v.rdy = rdy;     v.rsp_v = rv;   v.rsp_pc = rspc;
        v.ird = ird;       v.redir = redir; v.rpc = rpc;
        v.e_req = ereq;    v.e_addr = eaddr; v.e_iv = eiv;  v.e_pc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    // Assert reset, check reset values, release just after a rising edge.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        #1;
        chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
        chk1("rst_inst_valid", bus.inst_valid, 1'b0);
        chk("rst_inst_out", bus.inst_out, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_inst_pc_inc", bus.inst_pc_inc, 32'h4);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Drive one cycle of inputs, compare mid-cycle, advance past the next edge.
    task automatic apply_row(input vec_t v);
        if (v.rst_first) do_reset();
        bus.imem_req_ready = v.rdy;
        bus.imem_rsp_valid = v.rsp_v;
        bus.imem_rsp_data  = v.rsp_v ? mem_word(v.rsp_pc) : 32'hDEAD_BEEF;
        bus.inst_ready     = v.ird;
        bus.redirect_valid = v.redir;
        bus.redirect_pc    = v.rpc;
        #2;
        chk1("req_valid", bus.imem_req_valid, v.e_req);
        if (v.e_req) chk("req_addr", bus.imem_req_addr, v.e_addr);
        chk1("inst_valid", bus.inst_valid, v.e_iv);
        if (v.e_iv) begin
            chk("inst_pc", bus.inst_pc, v.e_pc);
            chk("inst_out", bus.inst_out, mem_word(v.e_pc));
            chk("inst_pc_inc", bus.inst_pc_inc, v.e_pc + 32'd4);
        end
        @(posedge clk);
        #1;
    endtask

    // Randomized traffic against a reference model: expected prefetch queue,
    // count of stale responses owed, and next fetch address.
    task automatic run_random(input int n);
        ment_t       mq[$];
        pend_t       pend[$];
        int          m_drop;
        logic [31:0] m_pc;
        int          last_due;
        int          unf;
        bit          e_req;
        bit          e_iv;
        bit          fire;
        logic [31:0] fire_addr;
        int          due;
        m_drop   = 0;
        m_pc     = 32'h0;
        last_due = -1;
        for (int c = 0; c < n; c++) begin
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            else
                bus.redirect_pc = $urandom;
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.inst_ready     = ($urandom_range(0, 3) != 0);
            if (pend.size() > 0 && pend[0].due <= c) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend[0].addr);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
            end

            unf = 0;
            foreach (mq[k]) if (!mq[k].filled) unf++;
            e_req = !bus.redirect_valid && (mq.size() + m_drop < DEPTH);
            e_iv  = !bus.redirect_valid && mq.size() > 0 && mq[0].filled;

            #2;
            chk1("rnd_req_valid", bus.imem_req_valid, e_req);
            if (e_req) chk("rnd_req_addr", bus.imem_req_addr, m_pc);
            chk1("rnd_inst_valid", bus.inst_valid, e_iv);
            if (e_iv) begin
                chk("rnd_inst_pc", bus.inst_pc, mq[0].pc);
                chk("rnd_inst_out", bus.inst_out, mq[0].inst);
                chk("rnd_inst_pc_inc", bus.inst_pc_inc, mq[0].pc + 32'd4);
            end
            fire      = bus.imem_req_valid && bus.imem_req_ready;
            fire_addr = bus.imem_req_addr;

            @(posedge clk);
            if (bus.redirect_valid) begin
                m_drop = m_drop + unf - (bus.imem_rsp_valid ? 1 : 0);
                mq.delete();
                m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (bus.imem_rsp_valid) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        for (int k = 0; k < mq.size(); k++) begin
                            if (!mq[k].filled) begin
                                mq[k].inst   = bus.imem_rsp_data;
                                mq[k].filled = 1'b1;
                                break;
                            end
                        end
                    end
                end
                if (e_iv && bus.inst_ready) void'(mq.pop_front());
                if (e_req && bus.imem_req_ready) begin
                    mq.push_back('{pc: m_pc, inst: 32'h0, filled: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
            if (bus.imem_rsp_valid) void'(pend.pop_front());
            if (fire) begin
                due = c + $urandom_range(1, 3);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: fire_addr, due: due});
            end
            #1;
        end
    endtask

    initial begin
        vec_t tbl[$];
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle_inputs();

        // Streaming, queue full with one pop, redirect with stall, redirect over a filled head.
        tbl.push_back(mk(1, 1,0,32'h0,   1,0,32'h0,   1,32'h0,   0,32'h0));
        tbl.push_back(mk(0, 1,1,32'h0,   1,0,32'h0,   1,32'h4,   0,32'h0));
        tbl.push_back(mk(0, 1,1,32'h4,   1,0,32'h0,   1,32'h8,   1,32'h0));
        tbl.push_back(mk(0, 1,1,32'h8,   0,0,32'h0,   1,32'hC,   1,32'h4));
        tbl.push_back(mk(0, 1,1,32'hC,   0,0,32'h0,   1,32'h10,  1,32'h4));
        tbl.push_back(mk(0, 1,1,32'h10,  0,0,32'h0,   0,32'h0,   1,32'h4));
        tbl.push_back(mk(0, 1,0,32'h0,   1,0,32'h0,   0,32'h0,   1,32'h4));
        tbl.push_back(mk(0, 1,0,32'h0,   0,0,32'h0,   1,32'h14,  1,32'h8));
        tbl.push_back(mk(0, 0,1,32'h14,  0,0,32'h0,   0,32'h0,   1,32'h8));
        tbl.push_back(mk(0, 1,0,32'h0,   1,1,32'h103, 0,32'h0,   0,32'h0));
        tbl.push_back(mk(0, 0,0,32'h0,   1,0,32'h0,   1,32'h100, 0,32'h0));
        tbl.push_back(mk(0, 0,0,32'h0,   1,0,32'h0,   1,32'h100, 0,32'h0));
        tbl.push_back(mk(0, 1,0,32'h0,   1,0,32'h0,   1,32'h100, 0,32'h0));
        tbl.push_back(mk(0, 1,1,32'h100, 1,0,32'h0,   1,32'h104, 0,32'h0));
        tbl.push_back(mk(0, 0,0,32'h0,   1,0,32'h0,   1,32'h108, 1,32'h100));
        tbl.push_back(mk(0, 0,1,32'h104, 1,0,32'h0,   1,32'h108, 0,32'h0));
        tbl.push_back(mk(0, 1,0,32'h0,   1,1,32'h200, 0,32'h0,   0,32'h0));
        tbl.push_back(mk(0, 1,0,32'h0,   1,0,32'h0,   1,32'h200, 0,32'h0));
        // Three outstanding, redirect to 0x103 while a response and inst_ready arrive.
        tbl.push_back(mk(1, 1,0,32'h0,   0,0,32'h0,   1,32'h0,   0,32'h0));
        tbl.push_back(mk(0, 1,0,32'h0,   0,0,32'h0,   1,32'h4,   0,32'h0));
        tbl.push_back(mk(0, 1,0,32'h0,   0,0,32'h0,   1,32'h8,   0,32'h0));
        tbl.push_back(mk(0, 0,1,32'h0,   1,1,32'h103, 0,32'h0,   0,32'h0));
        tbl.push_back(mk(0, 1,0,32'h0,   1,0,32'h0,   1,32'h100, 0,32'h0));
        tbl.push_back(mk(0, 1,0,32'h0,   1,0,32'h0,   1,32'h104, 0,32'h0));
        tbl.push_back(mk(0, 1,0,32'h0,   1,0,32'h0,   0,32'h0,   0,32'h0));
        tbl.push_back(mk(0, 1,1,32'h4,   1,0,32'h0,   0,32'h0,   0,32'h0));
        tbl.push_back(mk(0, 0,1,32'h8,   1,0,32'h0,   1,32'h108, 0,32'h0));
        tbl.push_back(mk(0, 0,1,32'h100, 0,0,32'h0,   1,32'h108, 0,32'h0));
        tbl.push_back(mk(0, 0,1,32'h104, 0,0,32'h0,   1,32'h108, 1,32'h100));
        tbl.push_back(mk(0, 0,0,32'h0,   1,0,32'h0,   1,32'h108, 1,32'h100));
        tbl.push_back(mk(0, 0,0,32'h0,   1,0,32'h0,   1,32'h108, 1,32'h104));
        // Request-ready stall pattern 1,0,0,1: address held, no skip or repeat.
        tbl.push_back(mk(1, 1,0,32'h0,   0,0,32'h0,   1,32'h0,   0,32'h0));
        tbl.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,32'h4,   0,32'h0));
        tbl.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,32'h4,   0,32'h0));
        tbl.push_back(mk(0, 1,0,32'h0,   0,0,32'h0,   1,32'h4,   0,32'h0));
        tbl.push_back(mk(0, 1,0,32'h0,   0,0,32'h0,   1,32'h8,   0,32'h0));

        do_reset();
        foreach (tbl[i]) apply_row(tbl[i]);

        // Fill the queue, then assert reset mid-cycle and check the outputs drop at once.
        do_reset();
        apply_row(mk(0, 1,0,32'h0, 0,0,32'h0, 1,32'h0, 0,32'h0));
        apply_row(mk(0, 1,1,32'h0, 0,0,32'h0, 1,32'h4, 0,32'h0));
        apply_row(mk(0, 1,1,32'h4, 0,0,32'h0, 1,32'h8, 1,32'h0));
        apply_row(mk(0, 1,1,32'h8, 0,0,32'h0, 1,32'hC, 1,32'h0));
        apply_row(mk(0, 0,1,32'hC, 0,0,32'h0, 0,32'h0, 1,32'h0));
        idle_inputs();
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk1("async_rst_req_valid", bus.imem_req_valid, 1'b0);
        chk1("async_rst_inst_valid", bus.inst_valid, 1'b0);
        chk("async_rst_inst_pc", bus.inst_pc, 32'h0);
        chk("async_rst_inst_out", bus.inst_out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply_row(mk(0, 1,0,32'h0, 0,0,32'h0, 1,32'h0, 0,32'h0));
        apply_row(mk(0, 1,1,32'h0, 0,0,32'h0, 1,32'h4, 0,32'h0));
        apply_row(mk(0, 0,0,32'h0, 1,0,32'h0, 1,32'h8, 1,32'h0));

        do_reset();
        run_random(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
